uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_tx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and parity helper, common to
// the transmitter and the future receiver.
package uart_pkg;

    localparam int unsigned DataBits = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Parity over one data byte: even parity is the plain XOR, odd inverts it.
    function automatic logic parity_bit(input logic [DataBits-1:0] data,
                                        input logic                odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: down-counter loaded with P-1, one-cycle tick on the
// last cycle of each period, automatic reload while enabled.
module uart_bit_timer #(
    parameter int unsigned Width = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [Width-1:0] i_period,
    output logic             o_tick
);

    localparam logic [Width-1:0] One = 1;

    logic [Width-1:0] cnt_q;

    // Count down through the period; reload P-1 on load or at period end.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_load || (i_en && (cnt_q == '0))) begin
            cnt_q <= i_period - One;
        end else if (i_en) begin
            cnt_q <= cnt_q - One;
        end
    end

    assign o_tick = i_en && (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional parity, 1 or 2 stop
// bits. Byte and line configuration are captured at the handshake and held
// for the whole frame so a config change never corrupts a frame in flight.
module uart_tx #(
    parameter int unsigned BaudCycBits = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [BaudCycBits-1:0] i_baud_cyc,
    input  logic                   c_parity_en,
    input  logic                   c_parity_odd,
    input  logic                   c_stop2,
    input  logic [7:0]             i_data,
    input  logic                   i_data_valid,
    output logic                   o_data_ready,
    output logic                   o_tx,
    output logic                   o_tx_busy
);

    import uart_pkg::*;

    localparam logic [BaudCycBits-1:0] One = 1;

    uart_state_t             state_q, state_d;
    logic [DataBits-1:0]     data_q;
    logic [BaudCycBits-1:0]  baud_q;
    logic                    par_en_q, par_odd_q, stop2_q;
    logic [2:0]              idx_q, idx_d;
    logic                    stop_hi_q, stop_hi_d;
    logic                    accept;
    logic                    tick;
    logic                    tx;
    logic                    busy;
    logic                    ready;
    logic [BaudCycBits-1:0]  period;

    // A programmed period of 0 behaves as 1 cycle per bit.
    function automatic logic [BaudCycBits-1:0] eff_period(input logic [BaudCycBits-1:0] b);
        return (b == '0) ? One : b;
    endfunction

    // The first bit is loaded from the live input at the handshake, all
    // later reloads from the captured copy.
    assign period = accept ? eff_period(i_baud_cyc) : eff_period(baud_q);

    uart_bit_timer #(
        .Width (BaudCycBits)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (accept),
        .i_en     (busy),
        .i_period (period),
        .o_tick   (tick)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, line level and handshake decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        stop_hi_d = stop_hi_q;
        accept    = 1'b0;
        ready     = 1'b0;
        busy      = 1'b1;
        tx        = 1'b1;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (i_data_valid) begin
                    accept  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                tx = data_q[idx_q];
                if (tick) begin
                    if (idx_q == 3'd7) begin
                        state_d   = par_en_q ? PARITY : STOP;
                        stop_hi_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                tx = parity_bit(data_q, par_odd_q);
                if (tick) begin
                    state_d   = STOP;
                    stop_hi_d = 1'b0;
                end
            end
            STOP: begin
                tx = 1'b1;
                // Two stop bits are one STOP state spanning two periods.
                if (tick) begin
                    if (stop2_q && !stop_hi_q) begin
                        stop_hi_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame registers: capture byte and config at the handshake.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q    <= '0;
            baud_q    <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            idx_q     <= '0;
            stop_hi_q <= 1'b0;
        end else begin
            if (accept) begin
                data_q    <= i_data;
                baud_q    <= i_baud_cyc;
                par_en_q  <= c_parity_en;
                par_odd_q <= c_parity_odd;
                stop2_q   <= c_stop2;
            end
            idx_q     <= idx_d;
            stop_hi_q <= stop_hi_d;
        end
    end

    assign o_tx         = tx;
    assign o_tx_busy    = busy;
    assign o_data_ready = ready;

endmodule
